// File: rtl/ifetch_queue.sv
// Instruction-fetch unit: PC sequencing and redirects, a single-outstanding
// instruction-memory handshake, and a small FIFO of fetched words toward decode.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                OFFSET_W = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic                is_branch,
  input  logic [ADDR_W-1:0]   branch_pc,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                is_jump,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rvalid,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic                inst_valid,
  output logic [DATA_W-1:0]   inst_data,
  output logic [ADDR_W-1:0]   inst_pc,
  input  logic                inst_ready
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam int                SHIFT = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, addr_n;
  logic [ADDR_W-1:0]  off_ext, branch_target, target;
  logic               redirect, push, pop;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_after;
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q   [DEPTH];

  // Offset is sign-extended to the full address width before scaling to bytes.
  assign off_ext       = ADDR_W'($signed(branch_offset));
  assign branch_target = branch_pc + (off_ext << SHIFT);
  assign target        = is_jump ? jump_addr : branch_target;
  assign redirect      = is_branch | is_jump;

  assign push        = (state == FETCH) & imem_rvalid & ~redirect;
  assign pop         = inst_valid & inst_ready & ~redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_q[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_q[rd_ptr] : '0;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = imem_addr;
    if (redirect) begin
      pc_n = target;
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            state_n = FETCH;
            addr_n  = target;
          end
        end
        default: begin
          // A request already on the bus must keep its address until answered.
          if (imem_rvalid) begin
            state_n = fetch_en ? FETCH : IDLE;
            if (fetch_en) addr_n = target;
          end else begin
            state_n = DRAIN;
          end
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en && count < FULL) begin
            state_n = FETCH;
            addr_n  = pc;
          end
        end
        FETCH: begin
          if (imem_rvalid) begin
            pc_n = pc + INC;
            if (fetch_en && count_after < FULL) begin
              addr_n = pc + INC;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_n = fetch_en ? FETCH : IDLE;
            if (fetch_en) addr_n = pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      imem_addr <= addr_n;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_after;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic against a
// queue-based model of the fetch stream and a variable-latency memory.
module tb_ifetch_queue;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int OFFSET_W = 16;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                fetch_en;
  logic                is_branch;
  logic [ADDR_W-1:0]   branch_pc;
  logic [OFFSET_W-1:0] branch_offset;
  logic                is_jump;
  logic [ADDR_W-1:0]   jump_addr;
  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_rvalid;
  logic [DATA_W-1:0]   imem_rdata;
  logic                inst_valid;
  logic [DATA_W-1:0]   inst_data;
  logic [ADDR_W-1:0]   inst_pc;
  logic                inst_ready;

  ifetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .is_branch(is_branch), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .is_jump(is_jump), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      fifo_m[$];
  logic [31:0] pc_m, out_addr;
  bit          out_m, stale, new_req;
  int          wait_left, wait_lo, wait_hi;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] redirect_target();
    int off;
    if (is_jump) return jump_addr;
    off = int'($signed(branch_offset));
    return branch_pc + 32'(off * (DATA_W / 8));
  endfunction

  task automatic reset_model();
    fifo_m.delete();
    pc_m      = 32'h0;
    out_addr  = 32'h0;
    out_m     = 0;
    stale     = 0;
    new_req   = 0;
    wait_left = 0;
  endtask

  task automatic issue(input bit go);
    out_m = go;
    if (go) begin
      out_addr = pc_m;
      stale    = 0;
      new_req  = 1;
    end
  endtask

  // Advances the model by one clock using the inputs held across the edge.
  task automatic update_model();
    bit          redir, rv;
    int          pre;
    logic [31:0] tgt;
    redir = is_branch || is_jump;
    rv    = imem_rvalid;
    pre   = fifo_m.size();
    tgt   = redirect_target();
    if (!redir && pre > 0 && inst_ready) void'(fifo_m.pop_front());
    if (redir) begin
      fifo_m.delete();
      pc_m = tgt;
    end
    if (out_m && rv) begin
      if (!stale && !redir) begin
        fifo_m.push_back('{pc: out_addr, data: imem_rdata});
        pc_m = out_addr + 32'd4;
      end
      issue(fetch_en && fifo_m.size() < DEPTH);
    end else if (out_m) begin
      if (redir) stale = 1;
      wait_left--;
    end else begin
      issue(fetch_en && (redir || pre < DEPTH));
    end
  endtask

  task automatic check_outputs();
    check("imem_req", imem_req, out_m);
    if (out_m) check("imem_addr", imem_addr, out_addr);
    check("inst_valid", inst_valid, fifo_m.size() > 0);
    if (fifo_m.size() > 0) begin
      check("inst_pc", inst_pc, fifo_m[0].pc);
      check("inst_data", inst_data, fifo_m[0].data);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    if (new_req) begin
      wait_left = $urandom_range(wait_hi, wait_lo);
      new_req   = 0;
    end
    imem_rvalid = out_m && (wait_left == 0);
    imem_rdata  = out_m ? mem_word(out_addr) : $urandom;
    #1 check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic clear_redirect();
    is_branch     = 1'b0;
    is_jump       = 1'b0;
    branch_pc     = '0;
    branch_offset = '0;
    jump_addr     = '0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    reset_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req,   1'b0);
    check({tag, "_addr"},  imem_addr,  32'h0);
    check({tag, "_valid"}, inst_valid, 1'b0);
    check({tag, "_data"},  inst_data,  32'h0);
    check({tag, "_pc"},    inst_pc,    32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    clear_redirect();
    reset_model();
    wait_lo = 0;
    wait_hi = 0;
    @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait streaming: one instruction per cycle, sequential PCs.
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) check("t1_stream_pc", inst_pc, 32'(4 * (k - 2)));
      cycle();
    end

    // Decode stalled: exactly DEPTH pushes, then requests stop.
    do_reset();
    inst_ready = 1'b0;
    repeat (10) cycle();
    check("t2_req_stopped", imem_req, 1'b0);
    check("t2_head_pc", inst_pc, 32'h0);
    check("t2_count", fifo_m.size(), DEPTH);
    inst_ready = 1'b1;
    repeat (8) cycle();

    // Jump while a 2-cycle fetch is outstanding: stale word dropped.
    do_reset();
    wait_lo = 2;
    wait_hi = 2;
    repeat (2) cycle();
    is_jump   = 1'b1;
    jump_addr = 32'h100;
    cycle();
    clear_redirect();
    begin
      int budget = 20;
      while (!inst_valid && budget > 0) begin
        cycle();
        budget--;
      end
      check("t3_timeout", budget > 0, 1'b1);
    end
    check("t3_first_pc", inst_pc, 32'h100);
    repeat (6) cycle();

    // Branch target arithmetic, including negative offset and wrap-around.
    wait_lo  = 0;
    wait_hi  = 0;
    fetch_en = 1'b0;
    do_reset();
    fetch_en      = 1'b1;
    is_branch     = 1'b1;
    branch_pc     = 32'h40;
    branch_offset = 16'hFFFC;
    cycle();
    clear_redirect();
    check("t4_neg_target", imem_addr, 32'h30);
    repeat (3) cycle();
    is_branch     = 1'b1;
    branch_pc     = 32'hFFFF_FFF0;
    branch_offset = 16'h7FFF;
    cycle();
    clear_redirect();
    check("t4_wrap_target", imem_addr, 32'h0001_FFEC);
    repeat (4) cycle();

    // Branch and jump together while a response arrives: jump wins, data dropped.
    check("t5_rvalid_pending", imem_req, 1'b1);
    is_branch     = 1'b1;
    branch_pc     = 32'h1000;
    branch_offset = 16'h0010;
    is_jump       = 1'b1;
    jump_addr     = 32'h2000;
    cycle();
    clear_redirect();
    check("t5_jump_prio", imem_addr, 32'h2000);
    repeat (4) cycle();

    // Reset with a request in flight and three words buffered.
    do_reset();
    inst_ready = 1'b0;
    begin
      int budget = 20;
      while (fifo_m.size() != 3 && budget > 0) begin
        cycle();
        budget--;
      end
      check("t6_fill_timeout", budget > 0, 1'b1);
    end
    #1 check("t6_req_before", imem_req, 1'b1);
    reset = 1'b1;
    #1 check_reset_outputs("t6");
    reset_model();
    @(negedge clk);
    reset      = 1'b0;
    inst_ready = 1'b1;
    cycle();
    check("t6_first_req", imem_req, 1'b1);
    check("t6_first_addr", imem_addr, 32'h0);
    repeat (4) cycle();

    // Randomized traffic with variable memory latency.
    do_reset();
    wait_lo = 0;
    wait_hi = 2;
    for (int i = 0; i < 3000; i++) begin
      fetch_en   = ($urandom % 10) < 8;
      inst_ready = ($urandom % 10) < 7;
      clear_redirect();
      if ($urandom % 16 == 0) begin
        if ($urandom % 2 == 0) begin
          is_jump   = 1'b1;
          jump_addr = $urandom & 32'hFFFF_FFFC;
        end
        if ($urandom % 2 == 0) begin
          is_branch     = 1'b1;
          branch_pc     = $urandom & 32'hFFFF_FFFC;
          branch_offset = ($urandom % 4 == 0) ? 16'h8000 : 16'($urandom);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
